// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch sequencer: key edges, run/lap/pause FSM, prescaler, BCD MM:SS
// Displayed digits come from either the live time or the frozen lap register.
module stopwatch_ctrl #(
  parameter int DIV   = 50_000_000,
  parameter int CNT_W = 26
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KEY_SS,
  input  logic       KEY_LC,
  output logic [3:0] DIG0,
  output logic [3:0] DIG1,
  output logic [3:0] DIG2,
  output logic [3:0] DIG3,
  output logic       RUNNING,
  output logic       LAP_ACT,
  output logic       WRAP
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LAP = 2'd2, PAUSE = 2'd3} state_t;

  localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV - 1);

  state_t           state;
  logic             ss_q, lc_q;
  logic             ss_p, lc_p;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             tick;
  logic [3:0]       t0, t1, t2, t3;
  logic [3:0]       l0, l1, l2, l3;
  logic [3:0]       n_t0, n_t1, n_t2, n_t3;
  logic             at_max;

  // Start/stop wins a simultaneous press; lap/clear is simply dropped.
  assign ss_p    = KEY_SS & ~ss_q;
  assign lc_p    = KEY_LC & ~lc_q & ~ss_p;
  assign RUNNING = (state == RUN) || (state == LAP);
  assign LAP_ACT = (state == LAP);
  assign tick    = (cnt == DIV_M1) && RUNNING;
  assign cnt_nxt = (cnt == DIV_M1) ? '0 : cnt + CNT_W'(1);
  assign at_max  = (t3 == 4'd5) && (t2 == 4'd9) && (t1 == 4'd5) && (t0 == 4'd9);

  always_comb begin
    n_t0 = t0 + 4'd1;
    n_t1 = t1;
    n_t2 = t2;
    n_t3 = t3;
    if (t0 == 4'd9) begin
      n_t0 = 4'd0;
      n_t1 = t1 + 4'd1;
      if (t1 == 4'd5) begin
        n_t1 = 4'd0;
        n_t2 = t2 + 4'd1;
        if (t2 == 4'd9) begin
          n_t2 = 4'd0;
          n_t3 = (t3 == 4'd5) ? 4'd0 : t3 + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      {t3, t2, t1, t0}         <= 16'h0000;
      {l3, l2, l1, l0}         <= 16'h0000;
      {DIG3, DIG2, DIG1, DIG0} <= 16'h0000;
      WRAP  <= 1'b0;
      // Keys held through reset must not register as a press afterwards.
      ss_q  <= 1'b1;
      lc_q  <= 1'b1;
    end else begin
      ss_q <= KEY_SS;
      lc_q <= KEY_LC;
      WRAP <= 1'b0;
      if (tick) begin
        {t3, t2, t1, t0} <= {n_t3, n_t2, n_t1, n_t0};
        WRAP             <= at_max;
      end
      case (state)
        IDLE: begin
          cnt              <= '0;
          {t3, t2, t1, t0} <= 16'h0000;
          if (ss_p) state <= RUN;
        end
        RUN: begin
          cnt <= cnt_nxt;
          if (ss_p) state <= PAUSE;
          else if (lc_p) begin
            state            <= LAP;
            {l3, l2, l1, l0} <= {t3, t2, t1, t0};
          end
        end
        LAP: begin
          cnt <= cnt_nxt;
          if (ss_p) state <= PAUSE;
          else if (lc_p) state <= RUN;
        end
        PAUSE: begin
          if (ss_p) state <= RUN;
          else if (lc_p) begin
            state            <= IDLE;
            cnt              <= '0;
            {t3, t2, t1, t0} <= 16'h0000;
          end
        end
        default: state <= IDLE;
      endcase
      {DIG3, DIG2, DIG1, DIG0} <= (state == LAP) ? {l3, l2, l1, l0} : {t3, t2, t1, t0};
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed vector bench for stopwatch_ctrl (DIV=4 and DIV=2 instances)
module tb_stopwatch_ctrl;

  logic       CLK = 1'b0;
  logic       RST4, KEY_SS4, KEY_LC4, RUNNING4, LAP_ACT4, WRAP4;
  logic [3:0] D04, D14, D24, D34;
  logic       RST2, KEY_SS2, KEY_LC2, RUNNING2, LAP_ACT2, WRAP2;
  logic [3:0] D02, D12, D22, D32;
  logic [15:0] dig4, dig2;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        ss;
    logic        lc;
    int          cyc;
    logic [15:0] dig;
    logic        run;
    logic        lap;
  } vec_t;

  vec_t vt[12];

  always #5 CLK = ~CLK;

  assign dig4 = {D34, D24, D14, D04};
  assign dig2 = {D32, D22, D12, D02};

  stopwatch_ctrl #(.DIV(4), .CNT_W(3)) u4 (
    .CLK(CLK), .RST(RST4), .KEY_SS(KEY_SS4), .KEY_LC(KEY_LC4),
    .DIG0(D04), .DIG1(D14), .DIG2(D24), .DIG3(D34),
    .RUNNING(RUNNING4), .LAP_ACT(LAP_ACT4), .WRAP(WRAP4)
  );

  stopwatch_ctrl #(.DIV(2), .CNT_W(2)) u2 (
    .CLK(CLK), .RST(RST2), .KEY_SS(KEY_SS2), .KEY_LC(KEY_LC2),
    .DIG0(D02), .DIG1(D12), .DIG2(D22), .DIG3(D32),
    .RUNNING(RUNNING2), .LAP_ACT(LAP_ACT2), .WRAP(WRAP2)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int wcnt;
    int wn;
    RST4 = 1'b1; KEY_SS4 = 1'b1; KEY_LC4 = 1'b0;
    RST2 = 1'b1; KEY_SS2 = 1'b0; KEY_LC2 = 1'b0;

    //           ss    lc    cyc  dig       run   lap
    vt[0]  = '{1'b1, 1'b0, 41, 16'h0010, 1'b1, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 20, 16'h0010, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b0,  2, 16'h0010, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b0,  0, 16'h0011, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 10, 16'h0011, 1'b1, 1'b1};
    vt[5]  = '{1'b0, 1'b1,  1, 16'h0014, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 1'b0,  3, 16'h0014, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b1,  0, 16'h0014, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 1'b0,  1, 16'h0015, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 1'b0,  1, 16'h0015, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b1,  1, 16'h0000, 1'b0, 1'b0};
    vt[11] = '{1'b1, 1'b0,  5, 16'h0001, 1'b1, 1'b0};

    step(); step();
    RST4 = 1'b0;
    repeat (3) step();
    chk("rst_dig", dig4, 16'h0000);
    chk("rst_running", RUNNING4, 1'b0);
    chk("rst_lap_act", LAP_ACT4, 1'b0);
    chk("rst_wrap", WRAP4, 1'b0);
    KEY_SS4 = 1'b0;
    step();
    chk("held_key_idle", RUNNING4, 1'b0);

    for (int i = 0; i < 12; i++) begin
      KEY_SS4 = vt[i].ss;
      KEY_LC4 = vt[i].lc;
      step();
      KEY_SS4 = 1'b0;
      KEY_LC4 = 1'b0;
      repeat (vt[i].cyc) step();
      chk($sformatf("v%0d_dig", i), dig4, vt[i].dig);
      chk($sformatf("v%0d_running", i), RUNNING4, vt[i].run);
      chk($sformatf("v%0d_lap_act", i), LAP_ACT4, vt[i].lap);
      chk($sformatf("v%0d_wrap", i), WRAP4, 1'b0);
    end

    // Lap at 12:34, then reset while in LAP.
    RST2 = 1'b0;
    step();
    KEY_SS2 = 1'b1; step(); KEY_SS2 = 1'b0;
    repeat (1508) step();
    KEY_LC2 = 1'b1; step(); KEY_LC2 = 1'b0;
    step();
    chk("lap_1234_dig", dig2, 16'h1234);
    chk("lap_1234_lap_act", LAP_ACT2, 1'b1);
    RST2 = 1'b1;
    step();
    chk("midlap_rst_dig", dig2, 16'h0000);
    chk("midlap_rst_running", RUNNING2, 1'b0);
    chk("midlap_rst_lap_act", LAP_ACT2, 1'b0);
    chk("midlap_rst_wrap", WRAP2, 1'b0);
    RST2 = 1'b0;
    step();

    // Full hour at two cycles per second: carries and the single wrap pulse.
    wcnt = 0;
    wn   = 0;
    KEY_SS2 = 1'b1; step(); KEY_SS2 = 1'b0;
    for (int n = 1; n <= 7202; n++) begin
      step();
      if (WRAP2) begin
        wcnt++;
        wn = n;
      end
      if (n == 19)   chk("carry_0009", dig2, 16'h0009);
      if (n == 21)   chk("carry_0010", dig2, 16'h0010);
      if (n == 119)  chk("carry_0059", dig2, 16'h0059);
      if (n == 121)  chk("carry_0100", dig2, 16'h0100);
      if (n == 7200) chk("pre_wrap_5959", dig2, 16'h5959);
      if (n == 7201) chk("post_wrap_0000", dig2, 16'h0000);
    end
    chk("wrap_count", wcnt, 1);
    chk("wrap_cycle", wn, 7200);
    chk("run_after_wrap", RUNNING2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
